// File: rtl/rounder_pipe.sv
// rtl/rounder_pipe.sv - two-stage IEEE-754 round-and-pack unit with valid/ready handshake and accrued flags
module rounder_pipe #(
   parameter int                 PARM_EXP      = 8,
   parameter int                 PARM_MANT     = 23,
   parameter int                 PARM_RM       = 3,
   parameter logic [PARM_RM-1:0] PARM_RM_RNE   = 3'b000,
   parameter logic [PARM_RM-1:0] PARM_RM_RTZ   = 3'b001,
   parameter logic [PARM_RM-1:0] PARM_RM_RDN   = 3'b010,
   parameter logic [PARM_RM-1:0] PARM_RM_RUP   = 3'b011,
   parameter logic [PARM_RM-1:0] PARM_RM_RMM   = 3'b100,
   parameter logic [PARM_MANT-1:0] PARM_MANT_NAN = {1'b1, {PARM_MANT-1{1'b0}}}
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          Valid_i,
   output logic                          Ready_o,
   input  logic                          Sign_i,
   input  logic [PARM_EXP+1:0]           Exp_i,
   input  logic [PARM_MANT+2:0]          Mant_i,
   input  logic                          Sticky_i,
   input  logic                          Invalid_i,
   input  logic                          Inf_i,
   input  logic                          Zero_i,
   input  logic [PARM_RM-1:0]            Rounding_mode_i,
   output logic                          Valid_o,
   input  logic                          Ready_i,
   output logic [PARM_EXP+PARM_MANT:0]   Result_o,
   output logic [4:0]                    Fflags_o,
   output logic [4:0]                    Fflags_acc_o,
   input  logic                          Fflags_clr_i
);
   localparam int MW = PARM_MANT + 3;
   localparam int EW = PARM_EXP + 2;
   localparam int SW = PARM_EXP + 3;
   localparam int RW = PARM_EXP + PARM_MANT + 1;
   localparam logic [EW:0]   EXP_OVF = (EW+1)'((1 << PARM_EXP) - 1);
   localparam logic [SW-1:0] SH_MAX  = SW'(MW);

   logic                 s1_valid, s1_sign, s1_sticky, s1_tiny, s1_inv, s1_inf, s1_zero;
   logic [EW-1:0]        s1_exp;
   logic [MW-1:0]        s1_mant;
   logic [PARM_RM-1:0]   s1_rm;
   logic                 s2_en;

   logic                 in_tiny, rm_legal;
   logic [SW-1:0]        shamt_raw, shamt;
   logic [2*MW-1:0]      shift_vec;

   assign s2_en   = ~Valid_o | Ready_i;
   assign Ready_o = ~s1_valid | s2_en;

   // Denormalise: the low half of shift_vec collects every bit pushed out of the mantissa.
   always_comb begin
      in_tiny   = Exp_i[EW-1] | (Exp_i == '0);
      rm_legal  = (Rounding_mode_i == PARM_RM_RNE) | (Rounding_mode_i == PARM_RM_RTZ) |
                  (Rounding_mode_i == PARM_RM_RDN) | (Rounding_mode_i == PARM_RM_RUP) |
                  (Rounding_mode_i == PARM_RM_RMM);
      shamt_raw = SW'(1) - {Exp_i[EW-1], Exp_i};
      shamt     = (shamt_raw > SH_MAX) ? SH_MAX : shamt_raw;
      shift_vec = {Mant_i, {MW{1'b0}}} >> shamt;
   end

   always_ff @(posedge clk) begin
      if (Valid_i & Ready_o) begin
         s1_sign   <= Sign_i;
         s1_exp    <= in_tiny ? '0 : Exp_i;
         s1_mant   <= in_tiny ? shift_vec[2*MW-1:MW] : Mant_i;
         s1_sticky <= Sticky_i | (in_tiny & (|shift_vec[MW-1:0]));
         s1_tiny   <= in_tiny;
         s1_inv    <= Invalid_i | ~rm_legal;
         s1_inf    <= Inf_i;
         s1_zero   <= Zero_i;
         s1_rm     <= Rounding_mode_i;
      end
   end

   logic                  lsb, g, r, nx, inc, to_inf, ovf;
   logic [PARM_MANT+1:0]  sum;
   logic [PARM_MANT:0]    mant_post;
   logic [EW:0]           exp_post;
   logic [RW-1:0]         res_d;
   logic [4:0]            flags_d;

   always_comb begin
      lsb = s1_mant[2];
      g   = s1_mant[1];
      r   = s1_mant[0];
      nx  = g | r | s1_sticky;
      case (s1_rm)
         PARM_RM_RNE: inc = g & (r | s1_sticky | lsb);
         PARM_RM_RDN: inc = nx & s1_sign;
         PARM_RM_RUP: inc = nx & ~s1_sign;
         PARM_RM_RMM: inc = g;
         default:     inc = 1'b0;
      endcase

      sum = {1'b0, s1_mant[MW-1:2]} + {{(PARM_MANT+1){1'b0}}, inc};
      if (sum[PARM_MANT+1]) begin
         mant_post = sum[PARM_MANT+1:1];
         exp_post  = {1'b0, s1_exp} + (EW+1)'(1);
      end else begin
         mant_post = sum[PARM_MANT:0];
         // A subnormal that rounds up into the hidden bit becomes the smallest normal.
         exp_post  = ((s1_exp == '0) && sum[PARM_MANT]) ? (EW+1)'(1) : {1'b0, s1_exp};
      end

      ovf    = (exp_post >= EXP_OVF);
      to_inf = (s1_rm == PARM_RM_RNE) | (s1_rm == PARM_RM_RMM) |
               ((s1_rm == PARM_RM_RUP) & ~s1_sign) | ((s1_rm == PARM_RM_RDN) & s1_sign);

      res_d   = {s1_sign, exp_post[PARM_EXP-1:0], mant_post[PARM_MANT-1:0]};
      flags_d = {3'b000, s1_tiny & nx, nx};
      if (ovf) begin
         res_d   = to_inf ? {s1_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}}
                          : {s1_sign, {(PARM_EXP-1){1'b1}}, 1'b0, {PARM_MANT{1'b1}}};
         flags_d = 5'b00101;
      end
      if (s1_zero) begin
         res_d   = {s1_sign, {(RW-1){1'b0}}};
         flags_d = 5'b00000;
      end
      if (s1_inf) begin
         res_d   = {s1_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
         flags_d = 5'b00000;
      end
      if (s1_inv) begin
         res_d   = {1'b0, {PARM_EXP{1'b1}}, PARM_MANT_NAN};
         flags_d = 5'b10000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         Valid_o      <= 1'b0;
         Result_o     <= '0;
         Fflags_o     <= '0;
         Fflags_acc_o <= '0;
      end else begin
         if (Ready_o) s1_valid <= Valid_i;
         if (s2_en)   Valid_o  <= s1_valid;
         if (s2_en & s1_valid) begin
            Result_o <= res_d;
            Fflags_o <= flags_d;
         end
         Fflags_acc_o <= (Fflags_clr_i ? 5'b00000 : Fflags_acc_o) |
                         ((Valid_o & Ready_i) ? Fflags_o : 5'b00000);
      end
   end
endmodule

// File: tb/tb_rounder_pipe.sv
// tb/tb_rounder_pipe.sv - self-checking bench for rounder_pipe against an arithmetic rounding model
module tb_rounder_pipe;
   typedef struct packed {
      logic        sign;
      logic [9:0]  expo;
      logic [25:0] mant;
      logic        sticky, inv, inf, zero;
      logic [2:0]  rm;
   } op_t;
   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  flg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Valid_i = 1'b0, Ready_o, Sign_i = 1'b0, Sticky_i = 1'b0;
   logic        Invalid_i = 1'b0, Inf_i = 1'b0, Zero_i = 1'b0, Valid_o, Ready_i = 1'b0, Fflags_clr_i = 1'b0;
   logic [9:0]  Exp_i = '0;
   logic [25:0] Mant_i = '0;
   logic [2:0]  Rounding_mode_i = '0;
   logic [31:0] Result_o;
   logic [4:0]  Fflags_o, Fflags_acc_o;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   rounder_pipe dut (
      .clk(clk), .rst(rst), .Valid_i(Valid_i), .Ready_o(Ready_o), .Sign_i(Sign_i),
      .Exp_i(Exp_i), .Mant_i(Mant_i), .Sticky_i(Sticky_i), .Invalid_i(Invalid_i),
      .Inf_i(Inf_i), .Zero_i(Zero_i), .Rounding_mode_i(Rounding_mode_i), .Valid_o(Valid_o),
      .Ready_i(Ready_i), .Result_o(Result_o), .Fflags_o(Fflags_o), .Fflags_acc_o(Fflags_acc_o),
      .Fflags_clr_i(Fflags_clr_i)
   );

   // Value = mant * 2^(e-bias-25); round it to a multiple of the target ulp by integer division.
   function automatic exp_t model(input op_t op);
      exp_t   o;
      int     e, k, er;
      longint n, d, q, rem, qr;
      bit     inexact, above, tie, up, to_inf;
      if (op.inv || op.rm > 3'd4) return {32'h7FC00000, 5'b10000};
      if (op.inf)  return {op.sign, 8'hFF, 23'h0, 5'b00000};
      if (op.zero) return {op.sign, 31'h0, 5'b00000};
      e = int'($signed(op.expo));
      k = (e < 1) ? ((1 - e > 58) ? 58 : 1 - e) : 0;
      n = longint'(op.mant);
      d = longint'(1) << (k + 2);
      q = n / d;
      rem = n % d;
      inexact = (rem != 0) || op.sticky;
      above = (2 * rem > d) || (2 * rem == d && op.sticky);
      tie = (2 * rem == d) && !op.sticky;
      case (op.rm)
         3'd0: up = above || (tie && (q % 2 == 1));
         3'd2: up = inexact && op.sign;
         3'd3: up = inexact && !op.sign;
         3'd4: up = (2 * rem >= d);
         default: up = 1'b0;
      endcase
      qr = q + (up ? 1 : 0);
      er = (e < 1) ? 0 : e;
      if (qr >= (longint'(1) << 24)) begin
         qr = qr / 2;
         er = er + 1;
      end
      if (er == 0 && qr >= (longint'(1) << 23)) er = 1;
      if (er >= 255) begin
         to_inf = (op.rm == 3'd0) || (op.rm == 3'd4) || (op.rm == 3'd3 && !op.sign) || (op.rm == 3'd2 && op.sign);
         o.res = to_inf ? {op.sign, 8'hFF, 23'h0} : {op.sign, 8'hFE, 23'h7FFFFF};
         o.flg = 5'b00101;
      end else begin
         o.res = {op.sign, 8'(er), 23'(qr)};
         o.flg = {3'b000, (e < 1) && inexact, inexact};
      end
      return o;
   endfunction

   function automatic op_t mk(input bit sign, input int e, input logic [22:0] frac,
                              input bit g, input bit r, input bit st, input logic [2:0] rm);
      op_t op;
      op = '0;
      op.sign = sign;
      op.expo = 10'(e);
      op.mant = {1'b1, frac, g, r};
      op.sticky = st;
      op.rm = rm;
      return op;
   endfunction

   function automatic op_t rand_op();
      op_t op;
      op.sign = 1'($urandom);
      case ($urandom_range(0, 3))
         0:       op.expo = 10'(int'($urandom_range(0, 5)) - 3);
         1:       op.expo = 10'(int'($urandom_range(252, 256)));
         default: op.expo = 10'(int'($urandom_range(0, 299)) - 40);
      endcase
      op.mant = {1'b1, 25'($urandom)};
      if ($urandom_range(0, 7) == 0) op.mant[24:2] = '1;
      op.sticky = 1'($urandom);
      op.inv = ($urandom_range(0, 15) == 0);
      op.inf = ($urandom_range(0, 15) == 0);
      op.zero = ($urandom_range(0, 15) == 0);
      op.rm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      return op;
   endfunction

   task automatic drive(input op_t op);
      Sign_i = op.sign; Exp_i = op.expo; Mant_i = op.mant; Sticky_i = op.sticky;
      Invalid_i = op.inv; Inf_i = op.inf; Zero_i = op.zero; Rounding_mode_i = op.rm;
   endtask

   task automatic run_one(input op_t op, output logic [31:0] res, output logic [4:0] flg, output bit timeout);
      @(negedge clk);
      drive(op);
      Valid_i = 1'b1;
      Ready_i = 1'b1;
      @(negedge clk);
      Valid_i = 1'b0;
      timeout = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (Valid_o === 1'b1) begin
            timeout = 1'b0;
            break;
         end
         @(negedge clk);
      end
      res = Result_o;
      flg = Fflags_o;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if (Valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
      n_vec++; if (Ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", Ready_o); end
      n_vec++; if (Result_o !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", Result_o); end
      n_vec++; if (Fflags_o !== 5'b0) begin n_err++; $display("FAIL reset_fflags: got %b want 0", Fflags_o); end
      n_vec++; if (Fflags_acc_o !== 5'b0) begin n_err++; $display("FAIL reset_acc: got %b want 0", Fflags_acc_o); end
   endtask

   task automatic test_directed();
      op_t         ops[16];
      logic [31:0] want_r[16];
      logic [4:0]  want_f[16];
      logic [31:0] r;
      logic [4:0]  f;
      bit          to;
      ops[0]  = mk(0, 127, 23'h000001, 1, 0, 0, 3'd0); want_r[0]  = 32'h3F800002; want_f[0]  = 5'b00001;
      ops[1]  = mk(0, 127, 23'h000000, 1, 0, 0, 3'd0); want_r[1]  = 32'h3F800000; want_f[1]  = 5'b00001;
      ops[2]  = mk(0, 127, 23'h000000, 1, 0, 0, 3'd4); want_r[2]  = 32'h3F800001; want_f[2]  = 5'b00001;
      ops[3]  = mk(0, 254, 23'h7FFFFF, 1, 0, 0, 3'd0); want_r[3]  = 32'h7F800000; want_f[3]  = 5'b00101;
      ops[4]  = mk(0, 254, 23'h7FFFFF, 1, 0, 0, 3'd1); want_r[4]  = 32'h7F7FFFFF; want_f[4]  = 5'b00001;
      ops[5]  = mk(1, 254, 23'h7FFFFF, 1, 0, 0, 3'd3); want_r[5]  = 32'hFF7FFFFF; want_f[5]  = 5'b00001;
      ops[6]  = mk(0, 0, 23'h0, 0, 0, 0, 3'd0);        want_r[6]  = 32'h00400000; want_f[6]  = 5'b00000;
      ops[7]  = mk(0, -30, 23'h0, 0, 0, 0, 3'd0);      want_r[7]  = 32'h00000000; want_f[7]  = 5'b00011;
      ops[8]  = mk(0, -30, 23'h0, 0, 0, 0, 3'd3);      want_r[8]  = 32'h00000001; want_f[8]  = 5'b00011;
      ops[9]  = mk(0, 127, 23'h0, 0, 0, 0, 3'd0); ops[9].inv = 1'b1; ops[9].inf = 1'b1;
      want_r[9] = 32'h7FC00000; want_f[9] = 5'b10000;
      ops[10] = mk(0, 127, 23'h0, 0, 0, 0, 3'd5);      want_r[10] = 32'h7FC00000; want_f[10] = 5'b10000;
      ops[11] = mk(1, 127, 23'h0, 1, 0, 0, 3'd0); ops[11].inf = 1'b1; ops[11].zero = 1'b1;
      want_r[11] = 32'hFF800000; want_f[11] = 5'b00000;
      ops[12] = mk(1, 127, 23'h0, 1, 0, 0, 3'd0); ops[12].zero = 1'b1;
      want_r[12] = 32'h80000000; want_f[12] = 5'b00000;
      ops[13] = mk(1, 127, 23'h0, 0, 1, 0, 3'd2);      want_r[13] = 32'hBF800001; want_f[13] = 5'b00001;
      ops[14] = mk(0, 255, 23'h0, 0, 0, 0, 3'd2);      want_r[14] = 32'h7F7FFFFF; want_f[14] = 5'b00101;
      ops[15] = mk(0, 0, 23'h7FFFFF, 1, 1, 0, 3'd0);   want_r[15] = 32'h00800000; want_f[15] = 5'b00011;
      for (int i = 0; i < 16; i++) begin
         run_one(ops[i], r, f, to);
         n_vec++;
         if (to || r !== want_r[i] || f !== want_f[i])
            begin n_err++; $display("FAIL directed[%0d]: got %h/%b timeout=%0d want %h/%b", i, r, f, to, want_r[i], want_f[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      op_t  ops[8];
      exp_t ex[8];
      for (int i = 0; i < 8; i++) begin
         ops[i] = rand_op();
         ex[i] = model(ops[i]);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         Ready_i = 1'b1;
         if (c < 8) begin drive(ops[c]); Valid_i = 1'b1; end
         else Valid_i = 1'b0;
         #1;
         n_vec++;
         if (c < 2) begin
            if (Valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_latency[%0d]: valid got %b want 0", c, Valid_o); end
         end else if (Valid_o !== 1'b1 || Result_o !== ex[c-2].res || Fflags_o !== ex[c-2].flg) begin
            n_err++;
            $display("FAIL b2b[%0d]: got v=%b %h/%b want v=1 %h/%b", c - 2, Valid_o, Result_o, Fflags_o, ex[c-2].res, ex[c-2].flg);
         end
      end
      @(negedge clk);
      Valid_i = 1'b0;
   endtask

   task automatic test_backpressure();
      op_t         ops[4];
      exp_t        ex[4];
      int          j = 0;
      logic [31:0] held = '0;
      for (int i = 0; i < 4; i++) begin
         ops[i] = rand_op();
         ex[i] = model(ops[i]);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         Ready_i = 1'b0;
         if (j < 4) begin drive(ops[j]); Valid_i = 1'b1; end
         #1;
         if (c == 3) held = Result_o;
         if (Valid_i && Ready_o) j++;
      end
      n_vec++; if (j != 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", j); end
      n_vec++; if (Ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", Ready_o); end
      n_vec++; if (Valid_o !== 1'b1 || Result_o !== held || Result_o !== ex[0].res)
         begin n_err++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", Valid_o, Result_o, ex[0].res); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         Ready_i = 1'b1;
         if (j < 4) begin drive(ops[j]); Valid_i = 1'b1; end
         else Valid_i = 1'b0;
         #1;
         n_vec++;
         if (c < 4) begin
            if (Valid_o !== 1'b1 || Result_o !== ex[c].res || Fflags_o !== ex[c].flg)
               begin n_err++; $display("FAIL bp_drain[%0d]: got v=%b %h/%b want v=1 %h/%b", c, Valid_o, Result_o, Fflags_o, ex[c].res, ex[c].flg); end
         end else if (Valid_o !== 1'b0) begin
            n_err++; $display("FAIL bp_empty: valid got %b want 0", Valid_o);
         end
         if (Valid_i && Ready_o) j++;
      end
      Valid_i = 1'b0;
   endtask

   task automatic test_random();
      localparam int N = 300;
      op_t         cur = '0;
      exp_t        e, q[$];
      int          sent = 0, got = 0;
      bit          have = 0, stalled = 0;
      logic [31:0] held_r = '0;
      logic [4:0]  held_f = '0;
      for (int c = 0; c < 4000 && got < N; c++) begin
         @(negedge clk);
         if (!have && sent < N && ($urandom % 4 != 0)) begin cur = rand_op(); have = 1; end
         if (have) begin drive(cur); Valid_i = 1'b1; end
         else Valid_i = 1'b0;
         Ready_i = ($urandom % 3 != 0);
         #1;
         if (stalled) begin
            n_vec++;
            if (Valid_o !== 1'b1 || Result_o !== held_r || Fflags_o !== held_f)
               begin n_err++; $display("FAIL rand_stall: got v=%b %h/%b want v=1 %h/%b", Valid_o, Result_o, Fflags_o, held_r, held_f); end
         end
         stalled = 0;
         if (Valid_o === 1'b1) begin
            if (Ready_i) begin
               n_vec++;
               if (q.size() == 0) begin
                  n_err++; $display("FAIL rand_extra: unexpected result %h want none", Result_o);
               end else begin
                  e = q.pop_front();
                  if (Result_o !== e.res || Fflags_o !== e.flg)
                     begin n_err++; $display("FAIL rand[%0d]: got %h/%b want %h/%b", got, Result_o, Fflags_o, e.res, e.flg); end
               end
               got++;
            end else begin
               stalled = 1; held_r = Result_o; held_f = Fflags_o;
            end
         end
         if (Valid_i && Ready_o) begin
            q.push_back(model(cur));
            have = 0;
            sent++;
         end
      end
      n_vec++;
      if (got != N) begin n_err++; $display("FAIL rand_count: got %0d results want %0d", got, N); end
      @(negedge clk);
      Valid_i = 1'b0;
   endtask

   task automatic test_fflags_acc();
      logic [31:0] r;
      logic [4:0]  f;
      bit          to;
      op_t         op;
      @(negedge clk);
      Ready_i = 1'b0;
      Fflags_clr_i = 1'b1;
      @(negedge clk);
      Fflags_clr_i = 1'b0;
      #1;
      n_vec++; if (Fflags_acc_o !== 5'b0) begin n_err++; $display("FAIL acc_clear: got %b want 00000", Fflags_acc_o); end
      op = mk(0, 127, 23'h0, 0, 0, 0, 3'd0);
      op.inv = 1'b1;
      run_one(op, r, f, to);
      @(negedge clk);
      Ready_i = 1'b0;
      #1;
      n_vec++; if (to || Fflags_acc_o !== 5'b10000) begin n_err++; $display("FAIL acc_nv: got %b timeout=%0d want 10000", Fflags_acc_o, to); end
      @(negedge clk);
      drive(mk(0, 127, 23'h000001, 1, 0, 0, 3'd0));
      Valid_i = 1'b1;
      @(negedge clk);
      Valid_i = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (Valid_o === 1'b1) begin to = 1'b0; break; end
         @(negedge clk);
      end
      Ready_i = 1'b1;
      Fflags_clr_i = 1'b1;
      @(negedge clk);
      Ready_i = 1'b0;
      Fflags_clr_i = 1'b0;
      #1;
      n_vec++; if (to || Fflags_acc_o !== 5'b00001) begin n_err++; $display("FAIL acc_clr_fire: got %b timeout=%0d want 00001", Fflags_acc_o, to); end
   endtask

   task automatic test_reset_midflight();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         Ready_i = 1'b0;
         drive(mk(0, 100 + c, 23'h123456, 1, 1, 0, 3'd0));
         Valid_i = 1'b1;
      end
      #1;
      n_vec++; if (Valid_o !== 1'b1 || Ready_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got v=%b rdy=%b want v=1 rdy=0", Valid_o, Ready_o); end
      @(negedge clk);
      Valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++; if (Valid_o !== 1'b0 || Ready_o !== 1'b1 || Result_o !== 32'h0 || Fflags_acc_o !== 5'b0)
         begin n_err++; $display("FAIL rst_mid: got v=%b rdy=%b %h acc=%b want v=0 rdy=1 0 acc=0", Valid_o, Ready_o, Result_o, Fflags_acc_o); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         Ready_i = 1'b1;
         #1;
         n_vec++; if (Valid_o !== 1'b0) begin n_err++; $display("FAIL rst_discard[%0d]: valid got %b want 0", c, Valid_o); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_fflags_acc();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
